// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding,
// the RISC-V NOP used as a bubble value, and a state-to-occupancy helper.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // addi x0, x0, 0 -- bubble value for instruction-carrying stages
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic [1:0] occupancy_of(state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side (in_*)
// and downstream side (out_*). The master drives the stage, the slave is the stage.
interface pipe_stage_skid_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mux_2to1.sv
// Generic 2:1 data multiplexer: y = sel ? b : a.
module mux_2to1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, a 2-entry skid buffer
// (main + skid) and synchronous flush that inserts a RESET_VALUE bubble.
// in_ready depends only on state, so there is no combinational path from
// out_ready to in_ready.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_skid_if.slave     bus,
    output logic [1:0]           occupancy
);

    state_t                state;
    state_t                state_next;
    logic                  skid_valid;
    logic                  in_fire;
    logic                  out_fire;
    logic                  drain;
    logic                  load_main;
    logic                  load_skid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [DATA_WIDTH-1:0] main_src;

    assign in_fire  = bus.in_valid  & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    // A FULL drain refills main from skid; every other main load takes in_data.
    assign drain     = skid_valid & out_fire;
    assign load_main = ((state == ST_EMPTY) & in_fire)
                     | ((state == ST_ONE) & in_fire & out_fire)
                     | drain;
    assign load_skid = (state == ST_ONE) & in_fire & ~out_fire;

    mux_2to1 #(
        .WIDTH (DATA_WIDTH)
    ) u_main_mux (
        .a   (bus.in_data),
        .b   (skid_data),
        .sel (drain),
        .y   (main_src)
    );

    // State register; reset returns to EMPTY.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_next;
    end

    // Next-state: flush beats every fire; skid-only (illegal) encoding recovers to EMPTY.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) state_next = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      state_next = ST_FULL;
                    else if (!in_fire && out_fire) state_next = ST_EMPTY;
                end
                ST_FULL:  if (out_fire) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Outputs derived from registered state and data only.
    always_comb begin
        skid_valid    = (state == ST_FULL);
        bus.out_valid = (state == ST_ONE) || (state == ST_FULL);
        bus.in_ready  = (state != ST_FULL);
        bus.out_data  = main_data;
        occupancy     = occupancy_of(state);
    end

    // Payload registers; reset and flush both restore the bubble value.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_data <= RESET_VALUE;
            skid_data <= RESET_VALUE;
        end else begin
            if (load_main) main_data <= main_src;
            if (load_skid) skid_data <= bus.in_data;
        end
    end

endmodule
